pkt_read_responder: RTL and testbench
=====================================

# pkt_read_responder

Centralized-packet-buffer side of the per-port packet-read and bufid-release interfaces used by the two network transmit ports (p0 toward the host control port, p1 toward the network). It accepts 16-bit read-address requests from both ports and arbitrates them round-robin onto a single buffer-RAM read port. It routes the 134-bit read data back to the requesting port with fixed latency. It also serializes the ports' bufid-release requests toward the buffer manager.

## Interface
- RD_LAT, 2, buffer RAM read latency in cycles from o_ram_rd to valid iv_ram_rdata; legal range 1..4.
- i_clk  in  1  single clock for all logic.
- i_rst  in  1  asynchronous, active-high reset.
- iv_pkt_raddr_p0 / iv_pkt_raddr_p1  in  16  read word address from port.
- i_pkt_rd_p0 / i_pkt_rd_p1  in  1  read request level, held with its address until acked.
- o_pkt_raddr_ack_p0 / o_pkt_raddr_ack_p1  out  1  one-cycle request-accepted pulse.
- ov_pkt_data_p0 / ov_pkt_data_p1  out  134  returned buffer word; both buses carry the same register.
- o_pkt_data_wr_p0 / o_pkt_data_wr_p1  out  1  data-valid strobe for that port.
- iv_pkt_bufid_p0 / iv_pkt_bufid_p1  in  9  bufid to release.
- i_pkt_bufid_wr_p0 / i_pkt_bufid_wr_p1  in  1  release request level, held until acked.
- o_pkt_bufid_ack_p0 / o_pkt_bufid_ack_p1  out  1  one-cycle release-accepted pulse.
- ov_free_bufid  out  9  bufid toward the buffer manager.
- o_free_bufid_wr  out  1  held until i_free_bufid_ack.
- i_free_bufid_ack  in  1  buffer manager accepted ov_free_bufid.
- ov_ram_raddr  out  16  buffer RAM read address.
- o_ram_rd  out  1  buffer RAM read strobe.
- iv_ram_rdata  in  134  RAM data, valid RD_LAT cycles after o_ram_rd.

## Operation
- Read eligibility:
  - A port is eligible when i_pkt_rd_pX=1 and its ack was not asserted in the current cycle. This blocks double-grant of a held request.
- Read arbitration:
  - At most one grant per cycle.
  - If both ports are eligible, the port opposite the last-granted port wins.
  - The last-granted pointer resets to p1, so p0 wins the first tie.
- Read grant (registered):
  - Next cycle: o_raddr_ack_pX=1, o_ram_rd=1, ov_ram_raddr=granted address.
  - A tag (valid, port) enters a RD_LAT+1 deep shift pipeline.
- Read return:
  - The tag emerging at depth RD_LAT captures iv_ram_rdata into the data register.
  - The following cycle raises o_pkt_data_wr for the tagged port only.
- Release FSM:
  - IDLE: if either i_pkt_bufid_wr_pX=1, choose round-robin with its own pointer (independent of the read pointer; p0 wins the first tie). Latch the bufid and pulse o_pkt_bufid_ack_pX. Go to SEND.
  - SEND: o_free_bufid_wr=1 with ov_free_bufid=latched value. On i_free_bufid_ack=1, drop wr next cycle and go to IDLE.
  - One release is in flight at most; a new one can start the cycle after returning to IDLE.
- Reset values: every output is 0, all pipeline tags are invalid, and the FSM is in IDLE.
- Reset mid-operation: outstanding reads are discarded, and no o_pkt_data_wr follows reset even if the RAM still returns data. A latched bufid in SEND is dropped; the port is not re-acked.

## Timing
- Read request seen at cycle N: ack and o_ram_rd at N+1; data and o_pkt_data_wr at N+1+RD_LAT+1 (N+4 for RD_LAT=2).
- Throughput:
  - One RAM read per cycle when both ports request.
  - A single port alone gets one read every 2 cycles, because it holds rd through its ack cycle.
- Simultaneous read request and release request are independent and both proceed.
- Data ordering per port equals grant order. A port never sees two o_pkt_data_wr pulses in consecutive cycles unless it had grants in consecutive cycles, which is impossible by the eligibility rule.
- Release request at N: ack pulse and o_free_bufid_wr rise at N+1. If i_free_bufid_ack=1 at cycle M, wr=0 at M+1 and IDLE at M+1. The earliest next ack is at M+2.

## Test plan
- Single read, RD_LAT=2: p0 raddr=0x0010 at cycle 5 with RAM word 0x3_ABCD… → ack_p0 and o_ram_rd at 6; ov_pkt_data_p0 equals that word with wr_p0=1 only at cycle 9; wr_p1 stays 0.
- Contention: both ports hold rd from cycle 0 with addresses 0x0100 and 0x0200, each dropping rd after its ack → grant order p0, p1, p0, p1… with o_ram_rd every cycle and no double ack of a held request.
- Held request: p1 keeps rd=1 with the same address for 3 cycles after its ack → a second grant occurs only at the cycle after ack, as a new request, with no back-to-back grant to p1.
- Release: both ports request with bufid 0x005 (p0) and 0x1FF (p1); i_free_bufid_ack is delayed 3 cycles each → 0x005 goes first, then 0x1FF, and o_free_bufid_wr is held until each ack.
- Reset mid-read: assert i_rst one cycle after o_ram_rd → no o_pkt_data_wr on either port afterward, and all outputs read 0 during reset.
- RD_LAT=4 sweep: 20 random alternating reads → every returned word matches its address's RAM content and arrives 6 cycles after its request.

Source files
------------

// File: rtl/pkt_read_responder.sv
// pkt_read_responder
// Buffer-side responder for the two transmit ports. p0 faces the host
// control port and p1 faces the network.
//
// Read path: each port presents a 16-bit word address with a level request.
// The requests are arbitrated round-robin onto the single buffer-RAM read
// port. The returned 134-bit word is handed back to the requesting port a
// fixed number of cycles later.
//
// Release path: each port presents a 9-bit bufid with a level request. The
// requests are serialized one at a time toward the buffer manager.
//
// Ports:
//   i_clk, i_rst                       clock, async active-high reset
//   iv_pkt_raddr_pX, i_pkt_rd_pX       read address / request per port
//   o_pkt_raddr_ack_pX                 one-cycle read-accepted pulse
//   ov_pkt_data_pX, o_pkt_data_wr_pX   returned word (shared register) / strobe
//   iv_pkt_bufid_pX, i_pkt_bufid_wr_pX release bufid / request per port
//   o_pkt_bufid_ack_pX                 one-cycle release-accepted pulse
//   ov_free_bufid, o_free_bufid_wr     bufid toward buffer manager, held
//   i_free_bufid_ack                   buffer manager took ov_free_bufid
//   ov_ram_raddr, o_ram_rd             buffer RAM read address / strobe
//   iv_ram_rdata                       RAM data, valid RD_LAT cycles after rd
module pkt_read_responder #(
   parameter int RD_LAT = 2
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic [15:0]  iv_pkt_raddr_p0,
   input  logic [15:0]  iv_pkt_raddr_p1,
   input  logic         i_pkt_rd_p0,
   input  logic         i_pkt_rd_p1,
   output logic         o_pkt_raddr_ack_p0,
   output logic         o_pkt_raddr_ack_p1,
   output logic [133:0] ov_pkt_data_p0,
   output logic [133:0] ov_pkt_data_p1,
   output logic         o_pkt_data_wr_p0,
   output logic         o_pkt_data_wr_p1,
   input  logic [8:0]   iv_pkt_bufid_p0,
   input  logic [8:0]   iv_pkt_bufid_p1,
   input  logic         i_pkt_bufid_wr_p0,
   input  logic         i_pkt_bufid_wr_p1,
   output logic         o_pkt_bufid_ack_p0,
   output logic         o_pkt_bufid_ack_p1,
   output logic [8:0]   ov_free_bufid,
   output logic         o_free_bufid_wr,
   input  logic         i_free_bufid_ack,
   output logic [15:0]  ov_ram_raddr,
   output logic         o_ram_rd,
   input  logic [133:0] iv_ram_rdata
);

   typedef enum logic {
      REL_IDLE,
      REL_SEND
   } rel_state_t;

   // Read-path state
   logic          raddr_ack_p0_q, raddr_ack_p0_d;
   logic          raddr_ack_p1_q, raddr_ack_p1_d;
   logic          ram_rd_q, ram_rd_d;
   logic [15:0]   ram_raddr_q, ram_raddr_d;
   logic          rd_last_q, rd_last_d;
   logic [RD_LAT:0] tag_vld_q, tag_vld_d;
   logic [RD_LAT:0] tag_port_q, tag_port_d;
   logic [133:0]  data_q, data_d;
   logic          data_wr_p0_q, data_wr_p0_d;
   logic          data_wr_p1_q, data_wr_p1_d;

   // Release-path state
   rel_state_t    rel_state_q;
   logic          rel_last_q;
   logic [8:0]    free_bufid_q;
   logic          free_bufid_wr_q;
   logic          bufid_ack_p0_q;
   logic          bufid_ack_p1_q;

   logic elig_p0, elig_p1, grant_p0, grant_p1;

   // Read arbitration and return routing.
   // A port is blocked during its own ack cycle because it still holds
   // the request then; without this a single request would be granted twice.
   // rd_last_q = 1 means p1 was granted last, so p0 wins the next tie.
   // Tag entry 0 lines up with o_ram_rd. Entry RD_LAT lines up with valid
   // RAM data, so that entry decides capture and which port gets the strobe.
   always_comb begin
      elig_p0 = i_pkt_rd_p0 & ~raddr_ack_p0_q;
      elig_p1 = i_pkt_rd_p1 & ~raddr_ack_p1_q;
      grant_p0 = elig_p0 & (~elig_p1 | rd_last_q);
      grant_p1 = elig_p1 & ~grant_p0;

      raddr_ack_p0_d = grant_p0;
      raddr_ack_p1_d = grant_p1;
      ram_rd_d       = grant_p0 | grant_p1;
      ram_raddr_d    = ram_raddr_q;
      rd_last_d      = rd_last_q;
      if (grant_p0) begin
         ram_raddr_d = iv_pkt_raddr_p0;
         rd_last_d   = 1'b0;
      end else if (grant_p1) begin
         ram_raddr_d = iv_pkt_raddr_p1;
         rd_last_d   = 1'b1;
      end

      tag_vld_d  = {tag_vld_q[RD_LAT-1:0], ram_rd_d};
      tag_port_d = {tag_port_q[RD_LAT-1:0], grant_p1};

      data_d       = tag_vld_q[RD_LAT] ? iv_ram_rdata : data_q;
      data_wr_p0_d = tag_vld_q[RD_LAT] & ~tag_port_q[RD_LAT];
      data_wr_p1_d = tag_vld_q[RD_LAT] & tag_port_q[RD_LAT];
   end

   // Read-path registers. Reset clears the tags, so reads in flight never
   // produce a strobe after reset.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         raddr_ack_p0_q <= 1'b0;
         raddr_ack_p1_q <= 1'b0;
         ram_rd_q       <= 1'b0;
         ram_raddr_q    <= '0;
         rd_last_q      <= 1'b1;
         tag_vld_q      <= '0;
         tag_port_q     <= '0;
         data_q         <= '0;
         data_wr_p0_q   <= 1'b0;
         data_wr_p1_q   <= 1'b0;
      end else begin
         raddr_ack_p0_q <= raddr_ack_p0_d;
         raddr_ack_p1_q <= raddr_ack_p1_d;
         ram_rd_q       <= ram_rd_d;
         ram_raddr_q    <= ram_raddr_d;
         rd_last_q      <= rd_last_d;
         tag_vld_q      <= tag_vld_d;
         tag_port_q     <= tag_port_d;
         data_q         <= data_d;
         data_wr_p0_q   <= data_wr_p0_d;
         data_wr_p1_q   <= data_wr_p1_d;
      end
   end

   // Release FSM. It has its own round-robin pointer (1 = p1 last, so p0
   // wins the first tie). Requests are only sampled in IDLE, so a port that
   // still holds its request during the ack pulse is not accepted twice.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rel_state_q     <= REL_IDLE;
         rel_last_q      <= 1'b1;
         free_bufid_q    <= '0;
         free_bufid_wr_q <= 1'b0;
         bufid_ack_p0_q  <= 1'b0;
         bufid_ack_p1_q  <= 1'b0;
      end else begin
         bufid_ack_p0_q <= 1'b0;
         bufid_ack_p1_q <= 1'b0;
         case (rel_state_q)
            REL_IDLE: begin
               if (i_pkt_bufid_wr_p0 & (~i_pkt_bufid_wr_p1 | rel_last_q)) begin
                  free_bufid_q    <= iv_pkt_bufid_p0;
                  free_bufid_wr_q <= 1'b1;
                  bufid_ack_p0_q  <= 1'b1;
                  rel_last_q      <= 1'b0;
                  rel_state_q     <= REL_SEND;
               end else if (i_pkt_bufid_wr_p1) begin
                  free_bufid_q    <= iv_pkt_bufid_p1;
                  free_bufid_wr_q <= 1'b1;
                  bufid_ack_p1_q  <= 1'b1;
                  rel_last_q      <= 1'b1;
                  rel_state_q     <= REL_SEND;
               end
            end
            REL_SEND: begin
               if (i_free_bufid_ack) begin
                  free_bufid_wr_q <= 1'b0;
                  rel_state_q     <= REL_IDLE;
               end
            end
            default: rel_state_q <= REL_IDLE;
         endcase
      end
   end

   assign o_pkt_raddr_ack_p0 = raddr_ack_p0_q;
   assign o_pkt_raddr_ack_p1 = raddr_ack_p1_q;
   assign ov_pkt_data_p0     = data_q;
   assign ov_pkt_data_p1     = data_q;
   assign o_pkt_data_wr_p0   = data_wr_p0_q;
   assign o_pkt_data_wr_p1   = data_wr_p1_q;
   assign o_pkt_bufid_ack_p0 = bufid_ack_p0_q;
   assign o_pkt_bufid_ack_p1 = bufid_ack_p1_q;
   assign ov_free_bufid      = free_bufid_q;
   assign o_free_bufid_wr    = free_bufid_wr_q;
   assign ov_ram_raddr       = ram_raddr_q;
   assign o_ram_rd           = ram_rd_q;

endmodule

// File: tb/tb_pkt_read_responder.sv
// Testbench for pkt_read_responder. Two instances share every input except
// RAM read data: one uses RD_LAT=2 and one uses RD_LAT=4. Each instance has
// its own behavioral RAM with the matching latency.
module tb_pkt_read_responder;

   logic         clk;
   logic         rst;
   logic [15:0]  raddr_p0, raddr_p1;
   logic         rd_p0, rd_p1;
   logic [8:0]   bufid_p0, bufid_p1;
   logic         bufid_wr_p0, bufid_wr_p1;
   logic         free_ack;

   // Outputs of the RD_LAT=2 instance
   logic         a2_ack_p0, a2_ack_p1, a2_wr_p0, a2_wr_p1;
   logic [133:0] a2_data_p0, a2_data_p1;
   logic         a2_back_p0, a2_back_p1, a2_free_wr, a2_ram_rd;
   logic [8:0]   a2_free_bufid;
   logic [15:0]  a2_ram_raddr;
   logic [133:0] a2_rdata;

   // Outputs of the RD_LAT=4 instance
   logic         a4_ack_p0, a4_ack_p1, a4_wr_p0, a4_wr_p1;
   logic [133:0] a4_data_p0, a4_data_p1;
   logic         a4_back_p0, a4_back_p1, a4_free_wr, a4_ram_rd;
   logic [8:0]   a4_free_bufid;
   logic [15:0]  a4_ram_raddr;
   logic [133:0] a4_rdata;

   int n_compared;
   int n_mismatched;

   pkt_read_responder #(.RD_LAT(2)) u_dut2 (
      .i_clk(clk), .i_rst(rst),
      .iv_pkt_raddr_p0(raddr_p0), .iv_pkt_raddr_p1(raddr_p1),
      .i_pkt_rd_p0(rd_p0), .i_pkt_rd_p1(rd_p1),
      .o_pkt_raddr_ack_p0(a2_ack_p0), .o_pkt_raddr_ack_p1(a2_ack_p1),
      .ov_pkt_data_p0(a2_data_p0), .ov_pkt_data_p1(a2_data_p1),
      .o_pkt_data_wr_p0(a2_wr_p0), .o_pkt_data_wr_p1(a2_wr_p1),
      .iv_pkt_bufid_p0(bufid_p0), .iv_pkt_bufid_p1(bufid_p1),
      .i_pkt_bufid_wr_p0(bufid_wr_p0), .i_pkt_bufid_wr_p1(bufid_wr_p1),
      .o_pkt_bufid_ack_p0(a2_back_p0), .o_pkt_bufid_ack_p1(a2_back_p1),
      .ov_free_bufid(a2_free_bufid), .o_free_bufid_wr(a2_free_wr),
      .i_free_bufid_ack(free_ack),
      .ov_ram_raddr(a2_ram_raddr), .o_ram_rd(a2_ram_rd),
      .iv_ram_rdata(a2_rdata)
   );

   pkt_read_responder #(.RD_LAT(4)) u_dut4 (
      .i_clk(clk), .i_rst(rst),
      .iv_pkt_raddr_p0(raddr_p0), .iv_pkt_raddr_p1(raddr_p1),
      .i_pkt_rd_p0(rd_p0), .i_pkt_rd_p1(rd_p1),
      .o_pkt_raddr_ack_p0(a4_ack_p0), .o_pkt_raddr_ack_p1(a4_ack_p1),
      .ov_pkt_data_p0(a4_data_p0), .ov_pkt_data_p1(a4_data_p1),
      .o_pkt_data_wr_p0(a4_wr_p0), .o_pkt_data_wr_p1(a4_wr_p1),
      .iv_pkt_bufid_p0(bufid_p0), .iv_pkt_bufid_p1(bufid_p1),
      .i_pkt_bufid_wr_p0(bufid_wr_p0), .i_pkt_bufid_wr_p1(bufid_wr_p1),
      .o_pkt_bufid_ack_p0(a4_back_p0), .o_pkt_bufid_ack_p1(a4_back_p1),
      .ov_free_bufid(a4_free_bufid), .o_free_bufid_wr(a4_free_wr),
      .i_free_bufid_ack(free_ack),
      .ov_ram_raddr(a4_ram_raddr), .o_ram_rd(a4_ram_rd),
      .iv_ram_rdata(a4_rdata)
   );

   // Clock generation
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM content is a fixed function of the address
   function automatic logic [133:0] ram_word(input logic [15:0] a);
      return {6'h03, 16'hABCD, a, 80'h0, ~a};
   endfunction

   // Latency-modeled RAMs. Entry j holds the read issued j+1 cycles ago.
   // These RAMs are never reset, so a read issued before reset still
   // returns data after it.
   logic [16:0] rq2 [0:1];
   logic [16:0] rq4 [0:3];
   always @(posedge clk) begin
      rq2[0] <= {a2_ram_rd, a2_ram_raddr};
      rq2[1] <= rq2[0];
      rq4[0] <= {a4_ram_rd, a4_ram_raddr};
      for (int j = 1; j < 4; j++) rq4[j] <= rq4[j-1];
   end
   assign a2_rdata = rq2[1][16] ? ram_word(rq2[1][15:0]) : '1;
   assign a4_rdata = rq4[3][16] ? ram_word(rq4[3][15:0]) : '1;

   // Advance one cycle and settle just after the active edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic r0, input logic [15:0] ad0,
                                input logic r1, input logic [15:0] ad1);
      rd_p0    = r0;
      raddr_p0 = ad0;
      rd_p1    = r1;
      raddr_p1 = ad1;
   endtask

   task automatic checkOutput(input string tag, input logic [133:0] got,
                              input logic [133:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Every output of both instances must read zero
   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_ack"}, {a2_ack_p0, a2_ack_p1, a4_ack_p0, a4_ack_p1}, 0);
      checkOutput({tag, "_wr"}, {a2_wr_p0, a2_wr_p1, a4_wr_p0, a4_wr_p1}, 0);
      checkOutput({tag, "_data2"}, a2_data_p0 | a2_data_p1, 0);
      checkOutput({tag, "_data4"}, a4_data_p0 | a4_data_p1, 0);
      checkOutput({tag, "_rel"}, {a2_back_p0, a2_back_p1, a2_free_wr, a2_free_bufid,
                                  a4_back_p0, a4_back_p1, a4_free_wr, a4_free_bufid}, 0);
      checkOutput({tag, "_ram"}, {a2_ram_rd, a2_ram_raddr, a4_ram_rd, a4_ram_raddr}, 0);
   endtask

   // Timeout guard
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      logic [15:0] a;
      logic        p;
      n_compared   = 0;
      n_mismatched = 0;
      rst = 1'b1;
      applyStimulus(0, 0, 0, 0);
      bufid_p0 = '0; bufid_p1 = '0;
      bufid_wr_p0 = 1'b0; bufid_wr_p1 = 1'b0;
      free_ack = 1'b0;

      // Reset state
      repeat (3) tick();
      checkAllZero("reset");
      rst = 1'b0;
      repeat (2) tick();

      // Contention: both ports request continuously, so grants alternate
      // starting with p0
      applyStimulus(1, 16'h0100, 1, 16'h0200);
      for (int k = 1; k <= 4; k++) begin
         tick();
         checkOutput($sformatf("cont_ack0_%0d", k), a2_ack_p0, (k % 2) == 1);
         checkOutput($sformatf("cont_ack1_%0d", k), a2_ack_p1, (k % 2) == 0);
         checkOutput($sformatf("cont_ramrd_%0d", k), a2_ram_rd, 1);
         checkOutput($sformatf("cont_raddr_%0d", k), a2_ram_raddr,
                     ((k % 2) == 1) ? 16'h0100 : 16'h0200);
         checkOutput($sformatf("cont_wr0_%0d", k), a2_wr_p0, k == 4);
         checkOutput($sformatf("cont_wr1_%0d", k), a2_wr_p1, 0);
         if (k == 4) begin
            checkOutput("cont_data_4", a2_data_p0, ram_word(16'h0100));
            applyStimulus(0, 0, 0, 0);
         end
      end
      for (int k = 5; k <= 7; k++) begin
         tick();
         checkOutput($sformatf("cont_ramrd_%0d", k), a2_ram_rd, 0);
         checkOutput($sformatf("cont_wr0_%0d", k), a2_wr_p0, k == 6);
         checkOutput($sformatf("cont_wr1_%0d", k), a2_wr_p1, k != 6);
         checkOutput($sformatf("cont_data_%0d", k),
                     (k == 6) ? a2_data_p0 : a2_data_p1,
                     ram_word((k == 6) ? 16'h0100 : 16'h0200));
      end
      repeat (4) tick();

      // Single read on p0: ack at +1, data at +4 (RD_LAT=2) and +6 (RD_LAT=4)
      applyStimulus(1, 16'h0010, 0, 0);
      for (int k = 1; k <= 7; k++) begin
         tick();
         if (k == 1) begin
            checkOutput("single_ack0", a2_ack_p0, 1);
            checkOutput("single_ramrd", a2_ram_rd, 1);
            checkOutput("single_raddr", a2_ram_raddr, 16'h0010);
            applyStimulus(0, 0, 0, 0);
         end else begin
            checkOutput($sformatf("single_ack0_%0d", k), a2_ack_p0, 0);
         end
         checkOutput($sformatf("single_wr0_l2_%0d", k), a2_wr_p0, k == 4);
         checkOutput($sformatf("single_wr0_l4_%0d", k), a4_wr_p0, k == 6);
         checkOutput($sformatf("single_wr1_%0d", k), {a2_wr_p1, a4_wr_p1}, 0);
         if (k == 4) checkOutput("single_data_l2", a2_data_p0, ram_word(16'h0010));
         if (k == 6) checkOutput("single_data_l4", a4_data_p0, ram_word(16'h0010));
      end
      repeat (2) tick();

      // Held request on p1: never granted in back-to-back cycles
      applyStimulus(0, 0, 1, 16'h0300);
      for (int k = 1; k <= 5; k++) begin
         tick();
         checkOutput($sformatf("held_ack1_%0d", k), a2_ack_p1, (k == 1) || (k == 3));
         checkOutput($sformatf("held_ack0_%0d", k), a2_ack_p0, 0);
         if (k == 4) applyStimulus(0, 0, 0, 0);
      end
      repeat (6) tick();

      // Release: p0 wins the first tie, free_wr held until the ack
      bufid_p0 = 9'h005; bufid_wr_p0 = 1'b1;
      bufid_p1 = 9'h1FF; bufid_wr_p1 = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         checkOutput($sformatf("rel_back0_%0d", k), a2_back_p0, k == 1);
         checkOutput($sformatf("rel_back1_%0d", k), a2_back_p1, k == 5);
         checkOutput($sformatf("rel_wr_%0d", k), a2_free_wr, (k != 4) && (k != 8));
         if (k <= 3) checkOutput($sformatf("rel_bufid_%0d", k), a2_free_bufid, 9'h005);
         if (k >= 5 && k <= 7) checkOutput($sformatf("rel_bufid_%0d", k), a2_free_bufid, 9'h1FF);
         free_ack = (k == 3) || (k == 7);
         if (k == 1) bufid_wr_p0 = 1'b0;
         if (k == 5) bufid_wr_p1 = 1'b0;
      end
      repeat (2) tick();

      // Reset one cycle after o_ram_rd: no data strobe may follow
      applyStimulus(1, 16'h0400, 0, 0);
      tick();
      checkOutput("rstmid_ack0", a2_ack_p0, 1);
      checkOutput("rstmid_ramrd", a2_ram_rd, 1);
      applyStimulus(0, 0, 0, 0);
      tick();
      rst = 1'b1;
      #1;
      checkAllZero("rstmid_async");
      tick();
      checkAllZero("rstmid_held");
      rst = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         checkOutput($sformatf("rstmid_wr_%0d", k),
                     {a2_wr_p0, a2_wr_p1, a4_wr_p0, a4_wr_p1}, 0);
      end

      // RD_LAT=4: alternating random reads, each returning 6 cycles after request
      for (int i = 0; i < 20; i++) begin
         p = i[0];
         a = 16'($urandom);
         applyStimulus(!p, a, p, a);
         for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 1) begin
               checkOutput($sformatf("sweep%0d_ack", i), {a4_ack_p1, a4_ack_p0},
                           p ? 2'b10 : 2'b01);
               checkOutput($sformatf("sweep%0d_raddr", i), a4_ram_raddr, a);
               applyStimulus(0, 0, 0, 0);
            end
            checkOutput($sformatf("sweep%0d_wr_%0d", i, k), {a4_wr_p1, a4_wr_p0},
                        (k == 6) ? (p ? 2'b10 : 2'b01) : 2'b00);
            if (k == 6)
               checkOutput($sformatf("sweep%0d_data", i),
                           p ? a4_data_p1 : a4_data_p0, ram_word(a));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
